// File: rtl/vdp_super_pkg.sv
// Shared definitions for the super-resolution CPU write path:
// I/O port numbers, the reserved fetch window and the VRAM write entry.
package vdp_super_pkg;

   // cpu_port decode
   localparam logic [1:0] PORT_DATA     = 2'd0;
   localparam logic [1:0] PORT_ADDR_LO  = 2'd1;
   localparam logic [1:0] PORT_ADDR_MID = 2'd2;
   localparam logic [1:0] PORT_ADDR_HI  = 2'd3;

   // Horizontal positions whose VRAM slots belong to the fetch stage
   localparam logic [10:0] RESERVED_CX_LO = 11'd720;
   localparam logic [10:0] RESERVED_CX_HI = 11'd727;

   // One queued 16-bit VRAM write
   typedef struct packed {
      logic [16:0] addr;
      logic [15:0] data;
   } super_wr_entry_t;

   // Position of the next data byte inside the pixel being assembled
   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2
   } phase_t;

   function automatic logic cx_reserved(input logic [10:0] cx_val);
      return (cx_val >= RESERVED_CX_LO) && (cx_val <= RESERVED_CX_HI);
   endfunction

endpackage

// File: rtl/vdp_super_write_fifo.sv
// Small write queue: up to two pushes and one pop per clock, with a
// synchronous clear used to flush everything on a mode change.
module vdp_super_write_fifo
   import vdp_super_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic [1:0]                  push_cnt,
   input  super_wr_entry_t             push_entry0,
   input  super_wr_entry_t             push_entry1,
   input  logic                        pop,
   output super_wr_entry_t             head,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   super_wr_entry_t mem_reg [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [PW-1:0]   wr_ptr_plus1;
   logic [CW-1:0]   count_reg;
   logic [FIFO_DEPTH-1:0] we0;
   logic [FIFO_DEPTH-1:0] we1;

   assign wr_ptr_plus1 = wr_ptr_reg + PW'(1);

   // Per-slot write enables: first entry at wr_ptr, second entry right after it
   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
         assign we0[gi] = (push_cnt != 2'd0) && (wr_ptr_reg == PW'(gi));
         assign we1[gi] = (push_cnt == 2'd2) && (wr_ptr_plus1 == PW'(gi));
      end
   endgenerate

   // Storage array; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (we0[i]) begin
            mem_reg[i] <= push_entry0;
         end else if (we1[i]) begin
            mem_reg[i] <= push_entry1;
         end
      end
   end

   // Pointer and occupancy bookkeeping; count moves by pushes minus pops
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + PW'(push_cnt);
         rd_ptr_reg <= rd_ptr_reg + PW'(pop);
         count_reg  <= count_reg + CW'(push_cnt) - CW'(pop);
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/vdp_super_pixel_writer.sv
// CPU byte writes -> packed super_color / super_mid pixels -> 16-bit VRAM
// writes issued in the slots the super-res fetch stage leaves free.
module vdp_super_pixel_writer
   import vdp_super_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        vdp_super,
   input  logic        super_color,
   input  logic        super_mid,
   input  logic [10:0] cx,
   input  logic        cpu_wr,
   input  logic [1:0]  cpu_port,
   input  logic [7:0]  cpu_data,
   output logic        vram_wr,
   output logic [16:0] vram_wr_addr,
   output logic [15:0] vram_wr_data,
   output logic        busy,
   output logic        overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]      mode_reg;
   logic            active;
   logic            mode_changed;
   logic            flush;
   logic            is_color;
   phase_t          phase_reg, phase_next;
   logic [16:0]     addr_reg, addr_next;
   logic            overflow_reg, overflow_next;
   logic [7:0]      stage0_reg;
   logic [7:0]      stage1_reg;
   logic            vram_wr_reg;
   logic [16:0]     vram_wr_addr_reg;
   logic [15:0]     vram_wr_data_reg;
   logic [CW-1:0]   count;
   logic [CW-1:0]   free_entries;
   logic [1:0]      need;
   logic [1:0]      push_cnt;
   logic            data_wr;
   logic            addr_wr;
   logic            completing;
   logic            accept;
   logic            pop;
   super_wr_entry_t push_entry0;
   super_wr_entry_t push_entry1;
   super_wr_entry_t head;

   // Any change of the mode bits while enabled flushes the whole path.
   assign active       = vdp_super & (super_color | super_mid);
   assign mode_changed = active & (mode_reg != {super_color, super_mid});
   assign flush        = reset | ~active | mode_changed;
   assign is_color     = super_color;

   assign data_wr    = cpu_wr & active & ~mode_changed & (cpu_port == PORT_DATA);
   assign addr_wr    = cpu_wr & active & ~mode_changed & (cpu_port != PORT_DATA);
   assign completing = data_wr & (is_color ? (phase_reg == PH2) : (phase_reg == PH1));

   // Room is judged on the registered count, ignoring any pop this cycle.
   assign free_entries = CW'(FIFO_DEPTH) - count;
   assign need         = is_color ? 2'd2 : 2'd1;
   assign accept       = completing & (free_entries >= CW'(need));
   assign push_cnt     = accept ? need : 2'd0;

   // super_color: {G,B} at addr, {00,R} at addr+1; super_mid: {high,low}
   assign push_entry0.addr = addr_reg;
   assign push_entry0.data = is_color ? {stage1_reg, cpu_data} : {cpu_data, stage0_reg};
   assign push_entry1.addr = addr_reg + 17'd1;
   assign push_entry1.data = {8'h00, stage0_reg};

   // Pop on the edge closing a cx[1:0]==01 cycle so vram_wr lands on the 10 slot
   assign pop = (cx[1:0] == 2'b01) & ~cx_reserved(cx) & (count != '0) & ~flush;

   vdp_super_write_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .clear       (flush),
      .push_cnt    (push_cnt),
      .push_entry0 (push_entry0),
      .push_entry1 (push_entry1),
      .pop         (pop),
      .head        (head),
      .count       (count)
   );

   // Remember last cycle's mode bits to detect a switch
   always_ff @(posedge clk) begin
      mode_reg <= {super_color, super_mid};
   end

   // Next byte phase, write address and overflow flag
   always_comb begin
      phase_next    = phase_reg;
      addr_next     = addr_reg;
      overflow_next = overflow_reg;
      if (addr_wr) begin
         phase_next    = PH0;
         overflow_next = 1'b0;
         case (cpu_port)
            PORT_ADDR_LO:  addr_next[7:0]  = cpu_data;
            PORT_ADDR_MID: addr_next[15:8] = cpu_data;
            PORT_ADDR_HI:  addr_next[16]   = cpu_data[0];
            default: ;
         endcase
      end else if (data_wr) begin
         if (completing) begin
            if (accept) begin
               phase_next = PH0;
               addr_next  = addr_reg + 17'(need);
            end else begin
               overflow_next = 1'b1;
            end
         end else begin
            phase_next = (phase_reg == PH0) ? PH1 : PH2;
         end
      end
   end

   // Pixel assembly state, staging bytes and VRAM output registers
   always_ff @(posedge clk) begin
      if (flush) begin
         phase_reg        <= PH0;
         addr_reg         <= '0;
         overflow_reg     <= 1'b0;
         stage0_reg       <= '0;
         stage1_reg       <= '0;
         vram_wr_reg      <= 1'b0;
         vram_wr_addr_reg <= '0;
         vram_wr_data_reg <= '0;
      end else begin
         phase_reg    <= phase_next;
         addr_reg     <= addr_next;
         overflow_reg <= overflow_next;
         if (data_wr && !completing) begin
            if (phase_reg == PH0) begin
               stage0_reg <= cpu_data;
            end else begin
               stage1_reg <= cpu_data;
            end
         end
         vram_wr_reg <= pop;
         if (pop) begin
            vram_wr_addr_reg <= head.addr;
            vram_wr_data_reg <= head.data;
         end
      end
   end

   assign vram_wr      = vram_wr_reg;
   assign vram_wr_addr = vram_wr_addr_reg;
   assign vram_wr_data = vram_wr_data_reg;
   assign busy         = (free_entries < CW'(2));
   assign overflow     = overflow_reg;

endmodule

// File: tb/tb_vdp_super_pixel_writer.sv
// Scoreboard bench: a queue-level model predicts every VRAM write and the
// per-cycle flags; a monitor compares the DUT against those predictions.
module tb_vdp_super_pixel_writer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vdp_super = 1'b0;
   logic        super_color = 1'b0;
   logic        super_mid = 1'b0;
   logic [10:0] cx = 11'd0;
   logic        cpu_wr = 1'b0;
   logic [1:0]  cpu_port = 2'd0;
   logic [7:0]  cpu_data = 8'd0;
   logic        vram_wr;
   logic [16:0] vram_wr_addr;
   logic [15:0] vram_wr_data;
   logic        busy;
   logic        overflow;

   always #5 clk = ~clk;

   vdp_super_pixel_writer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .vdp_super    (vdp_super),
      .super_color  (super_color),
      .super_mid    (super_mid),
      .cx           (cx),
      .cpu_wr       (cpu_wr),
      .cpu_port     (cpu_port),
      .cpu_data     (cpu_data),
      .vram_wr      (vram_wr),
      .vram_wr_addr (vram_wr_addr),
      .vram_wr_data (vram_wr_data),
      .busy         (busy),
      .overflow     (overflow)
   );

   typedef struct {
      logic [16:0] a;
      logic [15:0] d;
   } wr_t;

   int total = 0;
   int bad = 0;
   bit cx_hold = 1'b0;

   // reference model state
   wr_t         m_fifo[$];
   wr_t         sb[$];
   logic [7:0]  m_bytes[$];
   logic [16:0] m_addr = '0;
   logic        m_ovf = 1'b0;
   logic [1:0]  m_prev_mode = 2'd0;
   logic        exp_wr = 1'b0;
   logic        exp_busy = 1'b0;
   logic [16:0] exp_addr = '0;
   logic [15:0] exp_data = '0;

   // last observed write
   logic [16:0] last_addr = '0;
   logic [15:0] last_data = '0;
   int          last_cx = 0;
   int          n_writes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the behavioural model, using the inputs seen at this edge
   task automatic model_step();
      logic       act, chg, color;
      logic [1:0] mode;
      int         free, need, nb;
      wr_t        e;
      mode  = {super_color, super_mid};
      act   = vdp_super && (super_color || super_mid);
      chg   = act && (mode != m_prev_mode);
      m_prev_mode = mode;
      if (reset || !act || chg) begin
         m_fifo.delete();
         m_bytes.delete();
         m_addr = '0;
         m_ovf = 1'b0;
         exp_wr = 1'b0;
         exp_addr = '0;
         exp_data = '0;
      end else begin
         color = super_color;
         free = DEPTH - m_fifo.size();
         exp_wr = 1'b0;
         if ((cx % 4 == 1) && !(cx >= 720 && cx <= 727) && m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            exp_wr = 1'b1;
            exp_addr = e.a;
            exp_data = e.d;
            sb.push_back(e);
         end
         if (cpu_wr) begin
            if (cpu_port == 2'd0) begin
               m_bytes.push_back(cpu_data);
               nb = color ? 3 : 2;
               need = color ? 2 : 1;
               if (m_bytes.size() == nb) begin
                  if (free >= need) begin
                     if (color) begin
                        e.a = m_addr;          e.d = {m_bytes[1], m_bytes[2]}; m_fifo.push_back(e);
                        e.a = m_addr + 17'd1;  e.d = {8'h00, m_bytes[0]};      m_fifo.push_back(e);
                        m_addr = m_addr + 17'd2;
                     end else begin
                        e.a = m_addr;          e.d = {m_bytes[1], m_bytes[0]}; m_fifo.push_back(e);
                        m_addr = m_addr + 17'd1;
                     end
                     m_bytes.delete();
                  end else begin
                     void'(m_bytes.pop_back());
                     m_ovf = 1'b1;
                  end
               end
            end else begin
               case (cpu_port)
                  2'd1:    m_addr[7:0]  = cpu_data;
                  2'd2:    m_addr[15:8] = cpu_data;
                  default: m_addr[16]   = cpu_data[0];
               endcase
               m_bytes.delete();
               m_ovf = 1'b0;
            end
         end
      end
      exp_busy = (DEPTH - m_fifo.size()) < 2;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: per-cycle output check plus scoreboard pop on each write
   initial begin
      wr_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("vram_wr", vram_wr, exp_wr);
         chk("wr_addr_hold", vram_wr_addr, exp_addr);
         chk("wr_data_hold", vram_wr_data, exp_data);
         chk("busy", busy, exp_busy);
         chk("overflow", overflow, m_ovf);
         if (vram_wr === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_write: unexpected write addr=%05h data=%04h, expected none", vram_wr_addr, vram_wr_data);
            end else begin
               e = sb.pop_front();
               chk("sb_addr", vram_wr_addr, e.a);
               chk("sb_data", vram_wr_data, e.d);
            end
            n_writes++;
            last_addr = vram_wr_addr;
            last_data = vram_wr_data;
            last_cx = cx;
            $display("write #%0d addr=%05h data=%04h cx=%0d", n_writes, vram_wr_addr, vram_wr_data, cx);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic w, input logic [1:0] p, input logic [7:0] d);
      @(posedge clk);
      #2;
      cpu_wr = w;
      cpu_port = p;
      cpu_data = d;
      if (!cx_hold) cx = (cx == 11'd799) ? 11'd0 : cx + 11'd1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 2'd0, 8'd0);
   endtask

   task automatic wr(input logic [1:0] p, input logic [7:0] d);
      step(1'b1, p, d);
   endtask

   task automatic set_addr(input logic [16:0] a);
      wr(2'd1, a[7:0]);
      wr(2'd2, a[15:8]);
      wr(2'd3, {7'd0, a[16]});
   endtask

   task automatic set_mode(input logic c, input logic m);
      idle(1);
      vdp_super = 1'b1;
      super_color = c;
      super_mid = m;
      idle(2);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((m_fifo.size() > 0 || sb.size() > 0) && k < 400) begin
         idle(1);
         k++;
      end
      if (k >= 400) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d entries still pending, want 0", m_fifo.size() + sb.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int r;
      idle(3);
      reset = 1'b0;
      idle(1);
      chk("reset_vram_wr", vram_wr, 1'b0);
      chk("reset_addr", vram_wr_addr, 17'h0);
      chk("reset_data", vram_wr_data, 16'h0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_overflow", overflow, 1'b0);

      // super_color pixel at 0x00100
      set_mode(1'b1, 1'b0);
      set_addr(17'h00100);
      wr(2'd0, 8'h11); wr(2'd0, 8'h22); wr(2'd0, 8'h33);
      idle(1);
      wait_drain();
      chk("color_last_addr", last_addr, 17'h00101);
      chk("color_last_data", last_data, 16'h0011);
      chk("color_slot", last_cx % 4, 2);
      wr(2'd0, 8'h44); wr(2'd0, 8'h55); wr(2'd0, 8'h66);
      idle(1);
      wait_drain();
      chk("color_next_addr", last_addr, 17'h00103);

      // super_mid with address wrap
      set_mode(1'b0, 1'b1);
      set_addr(17'h1FFFF);
      wr(2'd0, 8'hCD); wr(2'd0, 8'hAB);
      idle(1);
      wait_drain();
      chk("mid_addr", last_addr, 17'h1FFFF);
      chk("mid_data", last_data, 16'hABCD);
      wr(2'd0, 8'h01); wr(2'd0, 8'h02);
      idle(1);
      wait_drain();
      chk("mid_wrap_addr", last_addr, 17'h00000);
      chk("mid_wrap_data", last_data, 16'h0201);

      // reserved cx window blocks issue
      cx_hold = 1'b1;
      cx = 11'd725;
      set_addr(17'h00200);
      wr(2'd0, 8'h5A); wr(2'd0, 8'hA5);
      base = n_writes;
      idle(12);
      chk("reserved_no_wr", n_writes, base);
      cx_hold = 1'b0;
      wait_drain();
      chk("reserved_first_cx", last_cx, 730);
      chk("reserved_data", last_data, 16'hA55A);

      // overflow with no free slots
      set_mode(1'b1, 1'b0);
      cx_hold = 1'b1;
      cx = 11'd721;
      set_addr(17'h00300);
      wr(2'd0, 8'hA1); wr(2'd0, 8'hA2); wr(2'd0, 8'hA3);
      wr(2'd0, 8'hB1); wr(2'd0, 8'hB2); wr(2'd0, 8'hB3);
      idle(1);
      chk("full_busy", busy, 1'b1);
      chk("full_no_ovf", overflow, 1'b0);
      wr(2'd0, 8'hC1); wr(2'd0, 8'hC2); wr(2'd0, 8'hC3);
      idle(1);
      chk("drop_overflow", overflow, 1'b1);
      wr(2'd1, 8'h00);
      idle(1);
      chk("addr_clears_ovf", overflow, 1'b0);
      base = n_writes;
      cx_hold = 1'b0;
      wait_drain();
      chk("overflow_writes", n_writes - base, 4);
      chk("overflow_last_addr", last_addr, 17'h00303);

      // flush by disabling super mode with 4 entries queued
      set_mode(1'b0, 1'b1);
      set_addr(17'h00500);
      wr(2'd0, 8'h12); wr(2'd0, 8'h34);
      idle(1);
      wait_drain();
      cx_hold = 1'b1;
      cx = 11'd721;
      for (int i = 0; i < 4; i++) begin
         wr(2'd0, 8'(i)); wr(2'd0, 8'(i + 8'h40));
      end
      idle(1);
      chk("mid_full_busy", busy, 1'b1);
      vdp_super = 1'b0;
      idle(1);
      chk("flush_vram_wr", vram_wr, 1'b0);
      chk("flush_addr", vram_wr_addr, 17'h0);
      chk("flush_data", vram_wr_data, 16'h0);
      chk("flush_busy", busy, 1'b0);
      base = n_writes;
      cx_hold = 1'b0;
      idle(20);
      chk("flush_no_wr", n_writes, base);

      // reset mid-pixel with pending entries
      set_mode(1'b1, 1'b0);
      cx_hold = 1'b1;
      cx = 11'd721;
      set_addr(17'h00600);
      wr(2'd0, 8'h61); wr(2'd0, 8'h62); wr(2'd0, 8'h63);
      wr(2'd0, 8'h77); wr(2'd0, 8'h88);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(1);
      chk("rst_vram_wr", vram_wr, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      wr(2'd0, 8'hAA); wr(2'd0, 8'hBB); wr(2'd0, 8'hCC);
      idle(1);
      cx_hold = 1'b0;
      wait_drain();
      chk("rst_last_addr", last_addr, 17'h00001);
      chk("rst_last_data", last_data, 16'h00AA);

      // randomized traffic
      cx = 11'(700 + $urandom_range(0, 40));
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 199);
         if (r < 80) begin
            wr(2'd0, 8'($urandom));
         end else if (r < 90) begin
            wr(2'($urandom_range(1, 3)), 8'($urandom));
         end else if (r < 92) begin
            idle(1);
            super_color = ~super_color;
            super_mid = ~super_color;
         end else if (r == 92) begin
            idle(1);
            vdp_super = 1'b0;
            idle(2);
            vdp_super = 1'b1;
         end else if (r < 96) begin
            idle(1);
            cx_hold = ~cx_hold;
         end else if (r == 96) begin
            idle(1);
            cx = 11'd715;
         end else begin
            idle(1);
         end
      end
      idle(1);
      cx_hold = 1'b0;
      wait_drain();
      idle(4);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
